// File: rtl/riscv_core_dcache_axi_bridge.sv
// D-cache memory-side bridge: line fills become single-beat 256-bit AXI reads and
// write-through stores become single-beat strobed AXI writes, each ending in a done pulse.
module riscv_core_dcache_axi_bridge #(
  parameter int ADDR_WIDTH      = 64,
  parameter int CORE_DATA_WIDTH = 64,
  parameter int AXI_DATA_WIDTH  = 256
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_mem_read_req,
  input  logic [ADDR_WIDTH-1:0]       i_mem_read_address,
  output logic                        o_mem_read_done,
  output logic [AXI_DATA_WIDTH-1:0]   o_mem_read_data,
  input  logic                        i_mem_write_valid,
  input  logic [CORE_DATA_WIDTH-1:0]  i_mem_write_data,
  input  logic [ADDR_WIDTH-1:0]       i_mem_write_address,
  input  logic [7:0]                  i_mem_write_strobe,
  output logic                        o_mem_write_done,
  output logic                        o_mem_error,
  output logic                        o_axi_arvalid,
  input  logic                        i_axi_arready,
  output logic [ADDR_WIDTH-1:0]       o_axi_araddr,
  input  logic                        i_axi_rvalid,
  output logic                        o_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   i_axi_rdata,
  input  logic [1:0]                  i_axi_rresp,
  output logic                        o_axi_awvalid,
  input  logic                        i_axi_awready,
  output logic [ADDR_WIDTH-1:0]       o_axi_awaddr,
  output logic                        o_axi_wvalid,
  input  logic                        i_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]   o_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] o_axi_wstrb,
  input  logic                        i_axi_bvalid,
  output logic                        o_axi_bready,
  input  logic [1:0]                  i_axi_bresp
);

  // Every transaction is one full-line beat: LEN=0, SIZE=5 (32 bytes), BURST=INCR.
  localparam logic [7:0] AXI_LEN     = 8'd0;
  localparam logic [2:0] AXI_SIZE    = 3'd5;
  localparam logic [1:0] AXI_BURST   = 2'b01;
  localparam int         STRB_WIDTH  = AXI_DATA_WIDTH / 8;
  localparam int         OFFSET_BITS = int'(AXI_SIZE);

  if (STRB_WIDTH != (1 << OFFSET_BITS) || AXI_LEN != 8'd0 || AXI_BURST != 2'b01) begin : g_bad_config
    $error("AXI_DATA_WIDTH must match a single-beat INCR transfer of size AXI_SIZE");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE_RD,
    DONE_WR
  } state_e;

  state_e state_q, state_d;

  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic bready_q, bready_d;
  logic read_done_q, read_done_d;
  logic write_done_q, write_done_d;
  logic error_q, error_d;

  logic load_read;
  logic load_write;
  logic capture_rdata;

  logic [ADDR_WIDTH-1:0]     araddr_q;
  logic [ADDR_WIDTH-1:0]     awaddr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0]     wstrb_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;

  // Lane placement of the store within the line; lanes shifted past the top are dropped.
  logic [OFFSET_BITS-1:0]    write_offset;
  logic [ADDR_WIDTH-1:0]     line_awaddr;
  logic [STRB_WIDTH-1:0]     lane_wstrb;
  logic [AXI_DATA_WIDTH-1:0] lane_wdata;

  assign write_offset = i_mem_write_address[OFFSET_BITS-1:0];
  assign line_awaddr  = {i_mem_write_address[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
  assign lane_wstrb   = STRB_WIDTH'(i_mem_write_strobe) << write_offset;
  assign lane_wdata   = AXI_DATA_WIDTH'(i_mem_write_data) << {write_offset, 3'b000};

  // Only the SLVERR/DECERR bit of each response matters to the controller.
  logic unused_resp_lsbs;
  assign unused_resp_lsbs = i_axi_rresp[0] ^ i_axi_bresp[0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d       = state_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    read_done_d   = 1'b0;
    write_done_d  = 1'b0;
    error_d       = 1'b0;
    load_read     = 1'b0;
    load_write    = 1'b0;
    capture_rdata = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_mem_read_req) begin
          state_d   = RD_ADDR;
          arvalid_d = 1'b1;
          load_read = 1'b1;
        end else if (i_mem_write_valid) begin
          state_d    = WR_REQ;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          load_write = 1'b1;
        end
      end
      RD_ADDR: begin
        if (i_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (i_axi_rvalid) begin
          rready_d      = 1'b0;
          capture_rdata = 1'b1;
          read_done_d   = 1'b1;
          error_d       = i_axi_rresp[1];
          state_d       = DONE_RD;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave only once neither is outstanding.
        if (i_axi_awready) awvalid_d = 1'b0;
        if (i_axi_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (i_axi_bvalid) begin
          bready_d     = 1'b0;
          write_done_d = 1'b1;
          error_d      = i_axi_bresp[1];
          state_d      = DONE_WR;
        end
      end
      // Requests are not sampled here: the controller drops them on seeing done.
      DONE_RD, DONE_WR: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (i_rst) begin
      state_q      <= IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      read_done_q  <= read_done_d;
      write_done_q <= write_done_d;
      error_q      <= error_d;
    end
  end

  // Payload registers only load on entry to a transaction, so they stay stable under valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      araddr_q <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (load_read) araddr_q <= i_mem_read_address;
      if (load_write) begin
        awaddr_q <= line_awaddr;
        wdata_q  <= lane_wdata;
        wstrb_q  <= lane_wstrb;
      end
      if (capture_rdata) rdata_q <= i_axi_rdata;
    end
  end

  assign o_axi_arvalid    = arvalid_q;
  assign o_axi_araddr     = araddr_q;
  assign o_axi_rready     = rready_q;
  assign o_axi_awvalid    = awvalid_q;
  assign o_axi_awaddr     = awaddr_q;
  assign o_axi_wvalid     = wvalid_q;
  assign o_axi_wdata      = wdata_q;
  assign o_axi_wstrb      = wstrb_q;
  assign o_axi_bready     = bready_q;
  assign o_mem_read_done  = read_done_q;
  assign o_mem_read_data  = rdata_q;
  assign o_mem_write_done = write_done_q;
  assign o_mem_error      = error_q;

endmodule
